// File: rtl/decay_pkg.sv
// Shared constants for the LIF decay scheduler: rate codes, FSM states and
// IEEE-754 single-precision field geometry.
package decay_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned RATE_W = 4;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  localparam logic [RATE_W-1:0] RATE_DIV1 = 4'b0001;
  localparam logic [RATE_W-1:0] RATE_DIV2 = 4'b0010;
  localparam logic [RATE_W-1:0] RATE_DIV4 = 4'b0100;
  localparam logic [RATE_W-1:0] RATE_DIV8 = 4'b1000;
  localparam logic [RATE_W-1:0] RATE_075  = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_e;

  // Exponent decrement for the power-of-two rates; unknown codes behave as /1.
  function automatic logic [EXP_W-1:0] rate_shift(input logic [RATE_W-1:0] rate);
    case (rate)
      RATE_DIV2: return EXP_W'(1);
      RATE_DIV4: return EXP_W'(2);
      RATE_DIV8: return EXP_W'(3);
      default:   return EXP_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/fp_decay_unit.sv
// Combinational decay of one single-precision potential: divide by 2^k via
// exponent subtraction, or multiply by 0.75, with flush-to-signed-zero.
module fp_decay_unit
  import decay_pkg::*;
(
  input  logic [FP_W-1:0]   pot_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic [FP_W-1:0]   result_o,
  output logic              flush_o
);

  logic              sign;
  logic [EXP_W-1:0]  expo;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  shift;
  logic [MANT_W:0]   sig;
  logic [MANT_W+1:0] sum;

  assign sign = pot_i[FP_W-1];
  assign expo = pot_i[FP_W-2 -: EXP_W];
  assign mant = pot_i[MANT_W-1:0];

  always_comb begin
    result_o = pot_i;
    flush_o  = 1'b0;
    shift    = rate_shift(rate_i);
    sig      = {1'b1, mant};
    sum      = {1'b0, sig} + {2'b00, sig[MANT_W:1]};

    if (expo == EXP_INF) begin
      result_o = pot_i;
    end else if (expo == EXP_W'(0)) begin
      result_o = {sign, {(FP_W-1){1'b0}}};
      flush_o  = 1'b1;
    end else if (rate_i == RATE_075) begin
      // sig + sig/2 = 1.5*sig; keeping the exponent (or e-1) yields 0.75x.
      if (expo <= EXP_W'(1)) begin
        result_o = {sign, {(FP_W-1){1'b0}}};
        flush_o  = 1'b1;
      end else if (sum[MANT_W+1]) begin
        result_o = {sign, expo, sum[MANT_W:1]};
      end else begin
        result_o = {sign, expo - EXP_W'(1), sum[MANT_W-1:0]};
      end
    end else begin
      if (expo <= shift) begin
        result_o = {sign, {(FP_W-1){1'b0}}};
        flush_o  = 1'b1;
      end else begin
        result_o = {sign, expo - shift, mant};
      end
    end
  end

endmodule

// File: rtl/decay_scheduler.sv
// Timestep sweep sequencer: read, decay and write back every neuron potential
// through a granted shared memory port. Optional DECAY_STATS_EN adds flush_count.
module decay_scheduler
  import decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              time_step,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [FP_W-1:0]   mem_rd_data,
  output logic              mem_wr_en,
  output logic [FP_W-1:0]   mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
`ifdef DECAY_STATS_EN
  ,
  output logic [ADDR_W:0]   flush_count
`endif
);

  localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] TBL_SIZE = ADDR_W'(NUM_NEURONS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [FP_W-1:0]     pot_q, pot_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [FP_W-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic [RATE_W-1:0]   rate_tbl_q [NUM_NEURONS];
  logic [RATE_W-1:0]   tbl_rate;
  logic [FP_W-1:0]     calc_result;
  logic                calc_flush;

  fp_decay_unit u_fp_decay_unit (
    .pot_i    (pot_q),
    .rate_i   (rate_q),
    .result_o (calc_result),
    .flush_o  (calc_flush)
  );

  assign tbl_rate = rate_tbl_q[idx_q[IDX_W-1:0]];

  // Rate table; out-of-range config addresses are dropped rather than aliased.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        rate_tbl_q[i] <= RATE_DIV1;
      end
    end else if (cfg_wr_en && (cfg_addr < TBL_SIZE)) begin
      rate_tbl_q[cfg_addr[IDX_W-1:0]] <= cfg_rate;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pot_q     <= '0;
      rate_q    <= RATE_DIV1;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pot_q     <= pot_d;
      rate_q    <= rate_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Strobes depend on the same-cycle grant, so they are decoded combinationally.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pot_d     = pot_q;
    rate_d    = rate_q;
    result_d  = result_q;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    overrun_d = time_step && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (time_step) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ: begin
        if (mem_gnt) begin
          mem_rd_en = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        pot_d   = mem_rd_data;
        rate_d  = tbl_rate;
        state_d = S_CALC;
      end
      S_CALC: begin
        result_d = calc_result;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (mem_gnt) begin
          mem_wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_WAIT) ||
             (state_d == S_CALC) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  assign mem_req     = busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign mem_addr    = idx_q;
  assign mem_wr_data = result_q;

`ifdef DECAY_STATS_EN
  logic [ADDR_W:0] flush_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && time_step) begin
      flush_cnt_q <= '0;
    end else if ((state_q == S_CALC) && calc_flush) begin
      flush_cnt_q <= flush_cnt_q + (ADDR_W+1)'(1);
    end
  end

  assign flush_count = flush_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = calc_flush;
`endif

endmodule

// File: tb/tb_decay_scheduler.sv
// Directed bench for decay_scheduler: vector table of potentials/rates swept
// through a modelled shared memory, plus grant, overrun and reset sequences.
module tb_decay_scheduler;

  localparam int unsigned N      = 16;
  localparam int unsigned ADDR_W = 12;

  logic              clock;
  logic              reset_n;
  logic              time_step;
  logic              cfg_wr_en;
  logic [ADDR_W-1:0] cfg_addr;
  logic [3:0]        cfg_rate;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              busy;
  logic              done;
  logic              overrun;
`ifdef DECAY_STATS_EN
  logic [ADDR_W:0]   flush_count;
`endif

  decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .time_step   (time_step),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_rate    (cfg_rate),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
`ifdef DECAY_STATS_EN
    ,
    .flush_count (flush_count)
`endif
  );

  typedef struct {
    logic [31:0] pot;
    logic [3:0]  rate;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [N];
  logic [31:0] mem [N];
  logic [31:0] pre_vals [N];
  logic        pre_en;
  logic        rand_gnt;
  logic        in_neuron;
  int          viol;
  int          wr_cnt;
  int          ovr_cnt;
  int          n_total;
  int          n_pass;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared potential memory: one-cycle read latency, preload port for the bench.
  always @(posedge clock) begin
    if (pre_en) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= pre_vals[i];
    end else begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr[3:0]];
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wr_data;
    end
  end

  // Protocol monitor: strobes only under grant, req held from read to write.
  always @(posedge clock) begin
    if (!reset_n) begin
      in_neuron <= 1'b0;
    end else begin
      if ((mem_rd_en || mem_wr_en) && !mem_gnt) viol <= viol + 1;
      else if (in_neuron && !mem_req) viol <= viol + 1;
      if (mem_rd_en) in_neuron <= 1'b1;
      if (mem_wr_en) in_neuron <= 1'b0;
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  // Grant driver: tied high, or dropped for bursts of 1..5 cycles.
  initial begin
    int hold;
    hold    = 0;
    mem_gnt = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (!rand_gnt) begin
        mem_gnt = 1'b1;
        hold    = 0;
      end else if (hold > 0) begin
        mem_gnt = 1'b0;
        hold--;
      end else if ($urandom_range(0, 2) == 0) begin
        mem_gnt = 1'b0;
        hold    = int'($urandom_range(0, 4));
      end else begin
        mem_gnt = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [3:0] r);
    @(posedge clock); #1;
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_rate  = r;
    @(posedge clock); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic preload_all(input logic [31:0] v);
    for (int i = 0; i < int'(N); i++) pre_vals[i] = v;
    @(posedge clock); #1 pre_en = 1'b1;
    @(posedge clock); #1 pre_en = 1'b0;
  endtask

  task automatic preload_vecs();
    for (int i = 0; i < int'(N); i++) pre_vals[i] = vecs[i].pot;
    @(posedge clock); #1 pre_en = 1'b1;
    @(posedge clock); #1 pre_en = 1'b0;
  endtask

  // Pulse time_step and count cycles until done; optionally re-pulse mid-sweep.
  task automatic run_sweep(input int reissue_at, input int budget, output int lat, output bit ok);
    @(posedge clock); #1 time_step = 1'b1;
    @(posedge clock); #1 time_step = 1'b0;
    lat = 1;
    while (!done && lat < budget) begin
      @(posedge clock); #1;
      lat++;
      time_step = (lat == reissue_at);
    end
    time_step = 1'b0;
    ok = done;
  endtask

  task automatic check_vecs(input string tag);
    for (int i = 0; i < int'(N); i++)
      chk($sformatf("%s_n%0d", tag, i), mem[i], vecs[i].exp);
  endtask

  initial begin
    int lat;
    bit ok;
    int ovr0;
    int wc;

    vecs[0]  = '{32'h41DED852, 4'b0100, 32'h40DED852};
    vecs[1]  = '{32'h41DED852, 4'b1000, 32'h405ED852};
    vecs[2]  = '{32'h41DED852, 4'b0011, 32'h41A7223D};
    vecs[3]  = '{32'h41DED852, 4'b0001, 32'h41DED852};
    vecs[4]  = '{32'h00800000, 4'b1000, 32'h00000000};
    vecs[5]  = '{32'hC1DED852, 4'b0010, 32'hC15ED852};
    vecs[6]  = '{32'h7FC00000, 4'b0010, 32'h7FC00000};
    vecs[7]  = '{32'h7FC00000, 4'b0011, 32'h7FC00000};
    vecs[8]  = '{32'h80000000, 4'b0010, 32'h80000000};
    vecs[9]  = '{32'h00000001, 4'b0001, 32'h00000000};
    vecs[10] = '{32'h3F800000, 4'b0011, 32'h3F400000};
    vecs[11] = '{32'h00800000, 4'b0011, 32'h00000000};
    vecs[12] = '{32'h01000000, 4'b0100, 32'h00000000};
    vecs[13] = '{32'h01800000, 4'b0100, 32'h00800000};
    vecs[14] = '{32'hFF800000, 4'b1000, 32'hFF800000};
    vecs[15] = '{32'h41DED852, 4'b0101, 32'h41DED852};

    n_total   = 0;
    n_pass    = 0;
    viol      = 0;
    wr_cnt    = 0;
    ovr_cnt   = 0;
    rand_gnt  = 1'b0;
    pre_en    = 1'b0;
    reset_n   = 1'b0;
    time_step = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_addr  = '0;
    cfg_rate  = 4'b0000;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", 32'({busy, done, overrun, mem_req, mem_rd_en, mem_wr_en}), 32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_wdata", mem_wr_data, 32'h0);
    reset_n = 1'b1;

    // Default table is /1: a sweep leaves potentials untouched.
    preload_all(32'h41DED852);
    run_sweep(0, 200, lat, ok);
    chk("default_done_lat", 32'(lat), 32'd65);
    chk("default_n0", mem[0], 32'h41DED852);
    chk("default_n15", mem[15], 32'h41DED852);

    // All /2, plus out-of-range config writes that must not alias onto neuron 0.
    for (int i = 0; i < int'(N); i++) cfg_write(ADDR_W'(i), 4'b0010);
    cfg_write(ADDR_W'(16), 4'b1000);
    cfg_write(12'hFFF, 4'b1000);
    preload_all(32'h41DED852);
    run_sweep(0, 200, lat, ok);
    chk("div2_done_lat", 32'(lat), 32'd65);
    for (int i = 0; i < int'(N); i++) chk($sformatf("div2_n%0d", i), mem[i], 32'h415ED852);

    // Vector table with grant tied high.
    for (int i = 0; i < int'(N); i++) cfg_write(ADDR_W'(i), vecs[i].rate);
    preload_vecs();
    run_sweep(0, 200, lat, ok);
    chk("vec_done_lat", 32'(lat), 32'd65);
    check_vecs("vec");
`ifdef DECAY_STATS_EN
    chk("flush_count", 32'(flush_count), 32'd5);
`endif

    // Same table with grant randomly withheld.
    rand_gnt = 1'b1;
    preload_vecs();
    run_sweep(0, 3000, lat, ok);
    chk("rgnt_done_seen", 32'(ok), 32'd1);
    rand_gnt = 1'b0;
    check_vecs("rgnt");

    // time_step reissued mid-sweep, then again in the DONE cycle.
    preload_vecs();
    ovr0 = ovr_cnt;
    run_sweep(20, 200, lat, ok);
    chk("ovr_done_lat", 32'(lat), 32'd65);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check_vecs("ovr");
    time_step = 1'b1;
    @(posedge clock); #1 time_step = 1'b0;
    chk("ovr_in_done", 32'(overrun), 32'd1);
    chk("ovr_in_done_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    chk("ovr_after_idle", 32'({busy, mem_req, overrun}), 32'h0);

    // Reset asserted while neuron 7 is being read.
    for (int i = 0; i < int'(N); i++) cfg_write(ADDR_W'(i), 4'b0010);
    preload_all(32'h41DED852);
    @(posedge clock); #1 time_step = 1'b1;
    @(posedge clock); #1 time_step = 1'b0;
    lat = 1;
    while (!(mem_rd_en && mem_addr == ADDR_W'(7)) && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("rst_reached_n7", 32'(lat < 100), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl_zero", 32'({busy, done, overrun, mem_req, mem_rd_en, mem_wr_en}), 32'h0);
    chk("rst_addr_zero", 32'(mem_addr), 32'h0);
    wc = wr_cnt;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("rst_no_writes", 32'(wr_cnt - wc), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    chk("rst_n6_written", mem[6], 32'h415ED852);
    chk("rst_n7_untouched", mem[7], 32'h41DED852);
    @(posedge clock); #1 time_step = 1'b1;
    @(posedge clock); #1 time_step = 1'b0;
    chk("restart_rd", 32'(mem_rd_en), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'h0);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("restart_done_lat", 32'(lat), 32'd65);
    chk("restart_n0_rate_reset", mem[0], 32'h415ED852);
    chk("restart_n10_rate_reset", mem[10], 32'h41DED852);

    repeat (2) @(posedge clock);
    #1;
    chk("protocol_violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decay_scheduler.md
Name: decay_scheduler

Overview:
Timestep sequencer for LIF membrane-potential decay across a neuron bank.
- On each `time_step` pulse it sweeps neuron addresses 0..NUM_NEURONS-1 in order. For each neuron it reads the IEEE-754 single potential from the shared potential memory, applies that neuron's configured decay rate, and writes the result back.
- Memory access is shared with the potential adder through a req/gnt handshake. The adder side owns arbitration.
- A per-neuron decay-rate table is held locally and written through a config port.

Parameters:
NUM_NEURONS, 16, neurons swept per timestep (≥2)
ADDR_W, 12, neuron address width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
time_step  in  1  one-cycle pulse; starts a sweep
cfg_wr_en  in  1  write decay-rate table
cfg_addr  in  ADDR_W  table index
cfg_rate  in  4  rate code: 0001 /1, 0010 /2, 0100 /4, 1000 /8, 0011 ×0.75; other codes = /1
mem_req  out  1  request for the potential memory port
mem_gnt  in  1  grant; port is usable only in cycles where this is high
mem_addr  out  ADDR_W  neuron address
mem_rd_en  out  1  read strobe; data is valid on the next cycle
mem_rd_data  in  32  potential read back
mem_wr_en  out  1  write strobe
mem_wr_data  out  32  decayed potential
busy  out  1  high from sweep start until done
done  out  1  one-cycle pulse after the last write
overrun  out  1  one-cycle pulse when time_step arrives while busy

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, index is 0, rate table is all 0001. Reset mid-sweep abandons the sweep; no partial write is issued after reset deasserts.
- States:
  - IDLE: on time_step go to READ with idx=0, busy=1.
  - READ: mem_req=1. When mem_gnt=1, drive mem_rd_en=1 and mem_addr=idx, then go to WAIT. Without grant, hold with no strobe.
  - WAIT: capture mem_rd_data and rate_table[idx] into registers, then go to CALC.
  - CALC: register the fp_decay_unit output, then go to WRITE.
  - WRITE: mem_req=1. When mem_gnt=1, drive mem_wr_en=1, mem_addr=idx, mem_wr_data=result.
    - If idx==NUM_NEURONS-1, go to DONE.
    - Otherwise increment idx and go to READ.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Timing: with gnt held high, each neuron takes 4 cycles. time_step to done is 4·NUM_NEURONS+1 cycles.
- mem_req stays high continuously across READ→WAIT→CALC→WRITE. It is released only in IDLE and DONE.
- time_step while busy is ignored and pulses overrun. A time_step in the DONE cycle also counts as overrun.
- A cfg write during a sweep takes effect for any neuron not yet captured in WAIT. A cfg write with cfg_addr ≥ NUM_NEURONS is ignored.
- Decay arithmetic (s = sign, e = exponent, m = mantissa):
  - Divide by 2^k: the result exponent is e−k; s and m are unchanged.
  - e==0 (zero or denormal): the result is a signed zero.
  - e==255 (Inf/NaN): the input passes through unchanged.
  - e ≤ k: underflow; flush to signed zero.
  - ×0.75 (code 0011): sig={1,m} (24b); sum=sig+(sig>>1) (25b, truncated).
    - If sum[24]==1: exp=e, mant=sum[23:1].
    - Else: exp=e−1, mant=sum[22:0].
    - If e ≤ 1: flush to signed zero.

Optional Feature:
DECAY_STATS_EN
- When defined, adds output `flush_count[ADDR_W:0]`. It is cleared at sweep start and increments for each neuron flushed to zero. It is valid and stable from done until the next sweep start.
- When undefined, the port and counter are absent and there is no other change.

Decomposition:
- decay_pkg: rate-code constants (RATE_DIV1/2/4/8, RATE_075), FSM state enum, FP field width/position constants (EXP_W=8, MANT_W=23, EXP_INF=255).
- Sub-module fp_decay_unit: purely combinational. Inputs are a 32-bit potential and a 4-bit rate; outputs are the 32-bit result and a flush flag. It contains all the arithmetic above, so the FSM holds no FP logic.

Test Plan:
- Rate 0010 for all neurons, memory preloaded with 0x41DED852, gnt tied high → every location reads 0x415ED852; done occurs 65 cycles after time_step (NUM_NEURONS=16).
- Per-neuron rates: n0=0100, n1=1000, n2=0011, n3=0001, all with 0x41DED852 → results 0x40DED852, 0x405ED852, 0x41A7223D, 0x41DED852.
- Boundaries:
  - 0x00800000 with rate 1000 → 0x00000000 (flush_count increments when the feature is enabled).
  - 0xC1DED852 with rate 0010 → 0xC15ED852.
  - 0x7FC00000 with any rate → unchanged.
- Grant randomly deasserted for 1–5 cycles → no strobes while gnt=0; final memory contents identical to the gnt-high run; mem_req never drops mid-neuron.
- time_step reissued mid-sweep → overrun pulses once and the sweep completes unaffected; reset_n asserted at neuron 7 → outputs 0 immediately, no further writes, and a new time_step restarts from address 0.
